instr_fetch_ctrl: RTL and testbench

INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

---
 rtl/instr_fetch_ctrl.sv | 103 ++++++++++
 tb/tb_instr_fetch_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, one-entry fetch output with
// backpressure, redirects, execute-permission and alignment faults.
module instr_fetch_ctrl #(
  parameter logic [7:0] RESET_PC = 8'h00,
  parameter logic [7:0] TRAP_PC  = 8'h3C
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_instr,
  input  logic [3:0]  pmp_xperm,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_addr,
  input  logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [7:0]  fetch_pc,
  input  logic        fault_clear,
  output logic        fault_valid,
  output logic [7:0]  fault_addr,
  output logic [1:0]  fault_cause,
  output logic [15:0] fetch_count
);

  typedef enum logic {FETCH = 1'b0, FAULT = 1'b1} state_t;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_XPERM = 2'b01;
  localparam logic [1:0] CAUSE_ALIGN = 2'b10;

  state_t     state;
  logic [7:0] pc;
  logic       slot_free;
  logic       perm_ok;
  logic       handshake;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign imem_addr = pc;
  assign slot_free = !fetch_valid || fetch_ready;
  assign perm_ok   = pmp_xperm[pc[7:6]];
  assign handshake = fetch_valid && fetch_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      fetch_instr <= '0;
      fetch_pc    <= '0;
      fault_valid <= 1'b0;
      fault_addr  <= '0;
      fault_cause <= CAUSE_NONE;
      fetch_count <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect_valid) begin
            // Redirect flushes the output slot; a pending handshake is dropped.
            fetch_valid <= 1'b0;
            if (redirect_addr[1:0] == 2'b00) begin
              pc <= redirect_addr;
            end else begin
              state       <= FAULT;
              fault_valid <= 1'b1;
              fault_addr  <= redirect_addr;
              fault_cause <= CAUSE_ALIGN;
            end
          end else begin
            if (handshake) fetch_count <= sat_inc(fetch_count);
            if (slot_free) begin
              if (perm_ok) begin
                fetch_instr <= imem_instr;
                fetch_pc    <= pc;
                fetch_valid <= 1'b1;
                pc          <= pc + 8'd4;
              end else begin
                state       <= FAULT;
                fault_valid <= 1'b1;
                fault_addr  <= pc;
                fault_cause <= CAUSE_XPERM;
                fetch_valid <= 1'b0;
              end
            end
          end
        end
        FAULT: begin
          fetch_valid <= 1'b0;
          if (fault_clear) begin
            state       <= FETCH;
            pc          <= TRAP_PC;
            fault_valid <= 1'b0;
            fault_cause <= CAUSE_NONE;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus randomized traffic,
// both checked every cycle against a transaction-level reference model.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic [3:0]  pmp_xperm;
  logic        redirect_valid;
  logic [7:0]  redirect_addr;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [7:0]  fetch_pc;
  logic        fault_clear;
  logic        fault_valid;
  logic [7:0]  fault_addr;
  logic [1:0]  fault_cause;
  logic [15:0] fetch_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [64];
  assign imem_instr = mem[imem_addr[7:2]];

  always #5 clk = ~clk;

  instr_fetch_ctrl #(.RESET_PC(8'h00), .TRAP_PC(8'h3C)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .pmp_xperm(pmp_xperm), .redirect_valid(redirect_valid),
    .redirect_addr(redirect_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_instr(fetch_instr), .fetch_pc(fetch_pc),
    .fault_clear(fault_clear), .fault_valid(fault_valid),
    .fault_addr(fault_addr), .fault_cause(fault_cause),
    .fetch_count(fetch_count)
  );

  // Reference model: next PC, the instruction slot, the fault record, the counter.
  int          m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  int          m_fpc;
  bit          m_fault;
  int          m_faddr;
  int          m_cause;
  int          m_count;

  task automatic model_reset();
    m_pc = 0; m_valid = 0; m_instr = 0; m_fpc = 0;
    m_fault = 0; m_faddr = 0; m_cause = 0; m_count = 0;
  endtask

  task automatic model_step();
    if (m_fault) begin
      if (fault_clear) begin
        m_fault = 0; m_cause = 0; m_pc = 'h3C;
      end
    end else if (redirect_valid) begin
      m_valid = 0;
      if (redirect_addr % 4 == 0) m_pc = redirect_addr;
      else begin m_fault = 1; m_faddr = redirect_addr; m_cause = 2; end
    end else begin
      bit accepted = m_valid && fetch_ready;
      if (accepted && m_count < 65535) m_count++;
      if (!m_valid || accepted) begin
        if (pmp_xperm[m_pc / 64]) begin
          m_instr = mem[m_pc / 4];
          m_fpc   = m_pc;
          m_valid = 1;
          m_pc    = (m_pc + 4) % 256;
        end else begin
          m_fault = 1; m_faddr = m_pc; m_cause = 1; m_valid = 0;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".imem_addr"},   32'(imem_addr),   32'(m_pc));
    chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(m_valid));
    chk({tag, ".fetch_pc"},    32'(fetch_pc),    32'(m_fpc));
    chk({tag, ".fetch_instr"}, fetch_instr,      m_instr);
    chk({tag, ".fault_valid"}, 32'(fault_valid), 32'(m_fault));
    chk({tag, ".fault_addr"},  32'(fault_addr),  32'(m_faddr));
    chk({tag, ".fault_cause"}, 32'(fault_cause), 32'(m_cause));
    chk({tag, ".fetch_count"}, 32'(fetch_count), 32'(m_count));
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic idle_inputs();
    redirect_valid = 0; redirect_addr = 0; fault_clear = 0; fetch_ready = 1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    rst = 1; pmp_xperm = 4'b0011;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    chk("reset.fetch_count_const", 32'(fetch_count), 32'h0);
    rst = 0;

    // Sequential fetch from address 0.
    step("seq0");
    chk("seq0.pc", 32'(fetch_pc), 32'h00);
    chk("seq0.instr", fetch_instr, mem[0]);
    step("seq1");
    chk("seq1.pc", 32'(fetch_pc), 32'h04);
    chk("seq1.instr", fetch_instr, mem[1]);
    chk("seq1.count", 32'(fetch_count), 32'd1);
    step("seq2");
    chk("seq2.pc", 32'(fetch_pc), 32'h08);
    chk("seq2.instr", fetch_instr, mem[2]);
    chk("seq2.count", 32'(fetch_count), 32'd2);

    // Backpressure holds the slot.
    fetch_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step("bp");
      chk("bp.pc", 32'(fetch_pc), 32'h08);
      chk("bp.instr", fetch_instr, mem[2]);
      chk("bp.count", 32'(fetch_count), 32'd2);
    end
    fetch_ready = 1;
    step("bp_release");
    chk("bp_release.pc", 32'(fetch_pc), 32'h0C);
    chk("bp_release.count", 32'(fetch_count), 32'd3);

    // Redirect into a non-executable quadrant.
    redirect_valid = 1; redirect_addr = 8'h80;
    step("xv_redir");
    chk("xv_redir.valid", 32'(fetch_valid), 32'd0);
    chk("xv_redir.count_flushed", 32'(fetch_count), 32'd3);
    redirect_valid = 0;
    step("xv_fault");
    chk("xv_fault.valid", 32'(fault_valid), 32'd1);
    chk("xv_fault.addr", 32'(fault_addr), 32'h80);
    chk("xv_fault.cause", 32'(fault_cause), 32'd1);
    redirect_valid = 1; redirect_addr = 8'h10;
    step("xv_ignore_redir");
    chk("xv_ignore_redir.pc", 32'(imem_addr), 32'h80);
    redirect_valid = 0; fault_clear = 1;
    step("xv_clear");
    chk("xv_clear.fault_valid", 32'(fault_valid), 32'd0);
    chk("xv_clear.addr_held", 32'(fault_addr), 32'h80);
    fault_clear = 0;
    step("xv_trap");
    chk("xv_trap.pc", 32'(fetch_pc), 32'h3C);
    chk("xv_trap.instr", fetch_instr, mem[15]);

    // Misaligned redirect.
    redirect_valid = 1; redirect_addr = 8'h42;
    step("mis");
    chk("mis.fault_valid", 32'(fault_valid), 32'd1);
    chk("mis.addr", 32'(fault_addr), 32'h42);
    chk("mis.cause", 32'(fault_cause), 32'd2);
    chk("mis.fetch_valid", 32'(fetch_valid), 32'd0);
    redirect_valid = 0; fault_clear = 1;
    step("mis_clear");
    fault_clear = 0;

    // Wrap from 0xFC to 0x00.
    pmp_xperm = 4'b1111;
    redirect_valid = 1; redirect_addr = 8'hFC;
    step("wrap_redir");
    redirect_valid = 0;
    step("wrap_fc");
    chk("wrap_fc.pc", 32'(fetch_pc), 32'hFC);
    step("wrap_00");
    chk("wrap_00.pc", 32'(fetch_pc), 32'h00);

    // Asynchronous reset while in FAULT.
    redirect_valid = 1; redirect_addr = 8'h81;
    step("pre_rst_fault");
    chk("pre_rst_fault.fault_valid", 32'(fault_valid), 32'd1);
    redirect_valid = 0;
    #2 rst = 1;
    #1;
    model_reset();
    chk("async_rst.fault_valid", 32'(fault_valid), 32'd0);
    chk("async_rst.count", 32'(fetch_count), 32'd0);
    chk_all("async_rst");
    #1 rst = 0;
    step("post_rst");
    chk("post_rst.pc", 32'(fetch_pc), 32'h00);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      fetch_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_addr  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom & 32'hFC);
      fault_clear    = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) pmp_xperm = 4'($urandom);
      if ($urandom_range(0, 99) == 0) begin
        #3 rst = 1;
        #1;
        model_reset();
        chk_all("rnd_rst");
        #1 rst = 0;
      end
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
